// File: rtl/minute_counter.sv
`default_nettype none
// ============================================================================
// Module   : minute_counter
// Purpose  : Minute stage of the alarm-clock timekeeping chain. Counts the
//            change_minute carry from the seconds stage in RUN mode and lets
//            debounced inc/dec buttons adjust the minutes in SET mode. Minutes
//            are held as two BCD digits (00..MAX_LEFT:MAX_RIGHT) for the
//            display mux. A one-cycle change_hour carry is sent to the hour
//            stage only on a RUN-mode wrap from MAX_LEFT:MAX_RIGHT to 00.
// Ports    :
//   clk            in   1  system clock, rising edge
//   rst            in   1  asynchronous reset, active low
//   change_minute  in   1  carry from seconds stage, counted on rising edge
//   set_en         in   1  1 = SET mode, 0 = RUN mode (level)
//   inc            in   1  button level, rising edge = +1 minute in SET
//   dec            in   1  button level, rising edge = -1 minute in SET
//   right_min      out  4  BCD units of minutes
//   left_min       out  4  BCD tens of minutes
//   change_hour    out  1  one-cycle carry pulse to the hour stage
// Revision : 1.0  initial release
// ============================================================================
module minute_counter #(
  parameter int MAX_LEFT  = 5,
  parameter int MAX_RIGHT = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       change_minute,
  input  logic       set_en,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] right_min,
  output logic [3:0] left_min,
  output logic       change_hour
);

  localparam logic [3:0] C_MAX_LEFT  = 4'(MAX_LEFT);
  localparam logic [3:0] C_MAX_RIGHT = 4'(MAX_RIGHT);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [3:0] r_right;
  logic [3:0] r_left;
  logic       r_change_hour;

  // Edge-detect history. These come out of reset high so that an input which
  // is already asserted when reset is released is not mistaken for an edge.
  logic       r_cm_hist;
  logic       r_inc_hist;
  logic       r_dec_hist;

  // --------------------------------------------------------------------------
  // Rising-edge events
  // --------------------------------------------------------------------------
  logic w_cm_ev;
  logic w_inc_ev;
  logic w_dec_ev;

  assign w_cm_ev  = change_minute & ~r_cm_hist;
  assign w_inc_ev = inc & ~r_inc_hist;
  assign w_dec_ev = dec & ~r_dec_hist;

  // --------------------------------------------------------------------------
  // Candidate increment / decrement values
  // --------------------------------------------------------------------------
  logic [3:0] w_up_right;
  logic [3:0] w_up_left;
  logic [3:0] w_dn_right;
  logic [3:0] w_dn_left;
  logic       w_at_max;

  assign w_at_max = (r_right == C_MAX_RIGHT) && (r_left == C_MAX_LEFT);

  always_comb begin
    w_up_right = r_right + 4'd1;
    w_up_left  = r_left;
    if (r_right == C_MAX_RIGHT) begin
      w_up_right = 4'd0;
      w_up_left  = (r_left == C_MAX_LEFT) ? 4'd0 : (r_left + 4'd1);
    end
  end

  always_comb begin
    w_dn_right = r_right - 4'd1;
    w_dn_left  = r_left;
    if (r_right == 4'd0) begin
      w_dn_right = C_MAX_RIGHT;
      w_dn_left  = (r_left == 4'd0) ? C_MAX_LEFT : (r_left - 4'd1);
    end
  end

  // --------------------------------------------------------------------------
  // Next-state selection
  // --------------------------------------------------------------------------
  logic [3:0] w_next_right;
  logic [3:0] w_next_left;
  logic       w_next_change_hour;

  always_comb begin
    w_next_right       = r_right;
    w_next_left        = r_left;
    w_next_change_hour = 1'b0;

    if (!set_en) begin
      // RUN: only the seconds carry counts; button edges are discarded.
      if (w_cm_ev) begin
        w_next_right       = w_up_right;
        w_next_left        = w_up_left;
        w_next_change_hour = w_at_max;
      end
    end else begin
      // SET: seconds carries are dropped, simultaneous inc+dec cancel out,
      // and a wrap never produces an hour carry.
      if (w_inc_ev && !w_dec_ev) begin
        w_next_right = w_up_right;
        w_next_left  = w_up_left;
      end else if (w_dec_ev && !w_inc_ev) begin
        w_next_right = w_dn_right;
        w_next_left  = w_dn_left;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_right       <= 4'd0;
      r_left        <= 4'd0;
      r_change_hour <= 1'b0;
      r_cm_hist     <= 1'b1;
      r_inc_hist    <= 1'b1;
      r_dec_hist    <= 1'b1;
    end else begin
      r_right       <= w_next_right;
      r_left        <= w_next_left;
      r_change_hour <= w_next_change_hour;
      r_cm_hist     <= change_minute;
      r_inc_hist    <= inc;
      r_dec_hist    <= dec;
    end
  end

  assign right_min   = r_right;
  assign left_min    = r_left;
  assign change_hour = r_change_hour;

endmodule
`default_nettype wire
